// File: rtl/audio_pkg.sv
// Shared types and constants for the audio sample feeder and its FIFO.
package audio_pkg;

    localparam int SAMPLE_W = 16;
    localparam int CH_LEFT  = 1;
    localparam int CH_RIGHT = 0;

    typedef enum logic {
        PAIR_IDLE  = 1'b0,
        PAIR_RIGHT = 1'b1
    } pair_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Register FIFO that can retire up to two entries per cycle, so a stranded
// right sample and the following left sample leave together.
module sample_fifo
    import audio_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = SAMPLE_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic [1:0]       pop_cnt,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [WIDTH-1:0] head_next_data,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] rd_ptr_plus1;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok;
    logic [1:0]       pop_eff;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;

    // A full FIFO refuses the push even when a pop retires an entry this cycle.
    assign push_ok = push && !full && !flush;

    always_comb begin
        pop_eff = pop_cnt;
        if (flush) begin
            pop_eff = 2'd0;
        end else if (LVL_W'(pop_cnt) > level_q) begin
            pop_eff = level_q[1:0];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_eff);
        level_d  = level_q - LVL_W'(pop_eff) + LVL_W'(push_ok);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign rd_ptr_plus1   = rd_ptr_q + PTR_W'(1);
    assign head_data      = mem_q[rd_ptr_q];
    assign head_next_data = mem_q[rd_ptr_plus1];

endmodule

// File: rtl/audio_sample_feeder.sv
// Buffers mixer PCM samples and hands them to the codec on request, with
// stereo pair alignment, mute and a saturating underrun counter.
module audio_sample_feeder
    import audio_pkg::*;
#(
    parameter  int DEPTH  = 16,
    parameter  int STEREO = 0,
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_data,
    output logic                in_ready,
    input  logic                flush,
    input  logic                enable,
    input  logic [1:0]          sample_req,
    output logic [SAMPLE_W-1:0] audio_output,
    output logic [1:0]          channel_sel,
    output logic [LVL_W-1:0]    level,
    output logic [7:0]          underrun_cnt
);

    logic [SAMPLE_W-1:0] head_data;
    logic [SAMPLE_W-1:0] head_next_data;
    logic                fifo_full;
    logic                fifo_empty;
    logic [1:0]          pop_cnt;
    logic                left_req;
    logic                right_req;

    pair_state_t         state_q, state_d;
    logic [SAMPLE_W-1:0] audio_q, audio_d;
    logic [7:0]          underrun_q, underrun_d;

    sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk            (clk),
        .reset          (reset),
        .push           (in_valid),
        .push_data      (in_data),
        .pop_cnt        (pop_cnt),
        .flush          (flush),
        .head_data      (head_data),
        .head_next_data (head_next_data),
        .level          (level),
        .full           (fifo_full),
        .empty          (fifo_empty)
    );

    assign in_ready     = !fifo_full;
    assign channel_sel  = (STEREO != 0) ? 2'b11 : 2'b10;
    assign audio_output = audio_q;
    assign underrun_cnt = underrun_q;

    // Left wins when both request bits arrive together.
    assign left_req  = sample_req[CH_LEFT];
    assign right_req = sample_req[CH_RIGHT] && !sample_req[CH_LEFT];

    always_comb begin
        state_d    = state_q;
        audio_d    = audio_q;
        underrun_d = underrun_q;
        pop_cnt    = 2'd0;

        if (flush) begin
            state_d = PAIR_IDLE;
        end else if (STEREO == 0) begin
            if (left_req) begin
                if (!enable) begin
                    audio_d = '0;
                end else if (!fifo_empty) begin
                    audio_d = head_data;
                    pop_cnt = 2'd1;
                end else begin
                    underrun_d = sat_inc8(underrun_q);
                end
            end
        end else begin
            if ((left_req || right_req) && !enable) begin
                audio_d = '0;
                state_d = PAIR_IDLE;
            end else if (left_req && state_q == PAIR_RIGHT) begin
                // Lost frame: the head is the stranded right sample; drop it
                // and start a fresh pair from what remains behind it.
                if (level >= LVL_W'(3)) begin
                    audio_d = head_next_data;
                    pop_cnt = 2'd2;
                    state_d = PAIR_RIGHT;
                end else begin
                    pop_cnt    = 2'd1;
                    underrun_d = sat_inc8(underrun_q);
                    state_d    = PAIR_IDLE;
                end
            end else if (left_req) begin
                // A left pop is taken only when its right partner is already
                // buffered, so the right request can never underrun.
                if (level >= LVL_W'(2)) begin
                    audio_d = head_data;
                    pop_cnt = 2'd1;
                    state_d = PAIR_RIGHT;
                end else begin
                    underrun_d = sat_inc8(underrun_q);
                end
            end else if (right_req && state_q == PAIR_RIGHT) begin
                audio_d = head_data;
                pop_cnt = 2'd1;
                state_d = PAIR_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= PAIR_IDLE;
            audio_q    <= '0;
            underrun_q <= '0;
        end else begin
            state_q    <= state_d;
            audio_q    <= audio_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Scoreboard bench for a mono and a stereo feeder sharing one clock.
module tb_audio_sample_feeder;
    import audio_pkg::*;

    localparam int DEPTH = 16;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset_m = 1'b0, reset_s = 1'b0;
    logic                in_valid_m = 1'b0, in_valid_s = 1'b0;
    logic [SAMPLE_W-1:0] in_data_m = '0, in_data_s = '0;
    logic                in_ready_m, in_ready_s;
    logic                flush_m = 1'b0, flush_s = 1'b0;
    logic                enable_m = 1'b1, enable_s = 1'b1;
    logic [1:0]          sample_req_m = '0, sample_req_s = '0;
    logic [SAMPLE_W-1:0] audio_output_m, audio_output_s;
    logic [1:0]          channel_sel_m, channel_sel_s;
    logic [LVL_W-1:0]    level_m, level_s;
    logic [7:0]          underrun_cnt_m, underrun_cnt_s;

    audio_sample_feeder #(.DEPTH(DEPTH), .STEREO(0)) dut_m (
        .clk          (clk),
        .reset        (reset_m),
        .in_valid     (in_valid_m),
        .in_data      (in_data_m),
        .in_ready     (in_ready_m),
        .flush        (flush_m),
        .enable       (enable_m),
        .sample_req   (sample_req_m),
        .audio_output (audio_output_m),
        .channel_sel  (channel_sel_m),
        .level        (level_m),
        .underrun_cnt (underrun_cnt_m)
    );

    audio_sample_feeder #(.DEPTH(DEPTH), .STEREO(1)) dut_s (
        .clk          (clk),
        .reset        (reset_s),
        .in_valid     (in_valid_s),
        .in_data      (in_data_s),
        .in_ready     (in_ready_s),
        .flush        (flush_s),
        .enable       (enable_s),
        .sample_req   (sample_req_s),
        .audio_output (audio_output_s),
        .channel_sel  (channel_sel_s),
        .level        (level_s),
        .underrun_cnt (underrun_cnt_s)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [SAMPLE_W-1:0] exp_q [$];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sample(input bit st, input logic [SAMPLE_W-1:0] d);
        if (st) begin
            in_valid_s = 1'b1;
            in_data_s  = d;
        end else begin
            in_valid_m = 1'b1;
            in_data_m  = d;
        end
        tick();
        in_valid_s = 1'b0;
        in_valid_m = 1'b0;
    endtask

    task automatic request(input bit st, input logic [1:0] r, input string tag);
        logic [SAMPLE_W-1:0] got;
        if (st) sample_req_s = r;
        else    sample_req_m = r;
        tick();
        sample_req_s = '0;
        sample_req_m = '0;
        got = st ? audio_output_s : audio_output_m;
        if (exp_q.size() == 0) begin
            check_value({tag, "_sb_nonempty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            check_value(tag, 32'(got), 32'(exp_q.pop_front()));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_level_m", 32'(level_m), 0);
        check_value("rst_audio_m", 32'(audio_output_m), 0);
        check_value("rst_cnt_m", 32'(underrun_cnt_m), 0);
        check_value("rst_ready_m", 32'(in_ready_m), 1);
        check_value("chsel_m", 32'(channel_sel_m), 32'b10);
        check_value("chsel_s", 32'(channel_sel_s), 32'b11);
        check_value("rst_audio_s", 32'(audio_output_s), 0);
        reset_m = 1'b1;
        reset_s = 1'b1;
        tick();

        // Mono: two samples, requests far apart.
        push_sample(0, 16'h1234);
        push_sample(0, 16'h5678);
        check_value("mono_level2", 32'(level_m), 2);
        exp_q.push_back(16'h1234);
        request(0, 2'b10, "mono_first");
        repeat (256) tick();
        exp_q.push_back(16'h5678);
        request(0, 2'b10, "mono_second");
        check_value("mono_level0", 32'(level_m), 0);

        // Mono: right request is ignored.
        exp_q.push_back(16'h5678);
        request(0, 2'b01, "mono_right_ignored");
        check_value("mono_right_cnt", 32'(underrun_cnt_m), 0);

        // Mono underrun saturation.
        for (int i = 0; i < 300; i++) begin
            exp_q.push_back(16'h5678);
            request(0, 2'b10, "mono_underrun_hold");
        end
        check_value("mono_cnt_sat", 32'(underrun_cnt_m), 32'hFF);
        check_value("mono_underrun_level", 32'(level_m), 0);
        push_sample(0, 16'h0ABC);
        check_value("mono_after_ur_level", 32'(level_m), 1);
        exp_q.push_back(16'h0ABC);
        request(0, 2'b10, "mono_after_ur");

        // Mono: fill to DEPTH, reject overflow, push+pop at full.
        for (int i = 0; i < DEPTH; i++) push_sample(0, 16'(16'h0100 + i));
        check_value("full_ready", 32'(in_ready_m), 0);
        check_value("full_level", 32'(level_m), DEPTH);
        push_sample(0, 16'hDEAD);
        check_value("full_reject_level", 32'(level_m), DEPTH);
        in_valid_m   = 1'b1;
        in_data_m    = 16'hBEEF;
        exp_q.push_back(16'h0100);
        request(0, 2'b10, "full_push_pop_out");
        in_valid_m   = 1'b0;
        check_value("full_push_pop_level", 32'(level_m), DEPTH - 1);
        for (int i = 1; i < DEPTH; i++) begin
            exp_q.push_back(16'(16'h0100 + i));
            request(0, 2'b10, "full_drain");
        end
        check_value("drain_level", 32'(level_m), 0);

        // Mono mute.
        push_sample(0, 16'h4321);
        enable_m = 1'b0;
        exp_q.push_back(16'h0000);
        request(0, 2'b10, "mute_out");
        enable_m = 1'b1;
        check_value("mute_level", 32'(level_m), 1);
        check_value("mute_cnt", 32'(underrun_cnt_m), 32'hFF);
        exp_q.push_back(16'h4321);
        request(0, 2'b10, "unmute_out");

        // Mono flush.
        push_sample(0, 16'h0F0F);
        push_sample(0, 16'h0E0E);
        flush_m = 1'b1;
        tick();
        flush_m = 1'b0;
        check_value("flush_level", 32'(level_m), 0);
        check_value("flush_audio", 32'(audio_output_m), 32'h4321);
        push_sample(0, 16'h0D0D);
        exp_q.push_back(16'h0D0D);
        request(0, 2'b10, "post_flush");

        // Stereo: pair then underrun with one sample left.
        push_sample(1, 16'hAAAA);
        push_sample(1, 16'hBBBB);
        push_sample(1, 16'h1111);
        exp_q.push_back(16'hAAAA);
        request(1, 2'b10, "st_left");
        exp_q.push_back(16'hBBBB);
        request(1, 2'b01, "st_right");
        exp_q.push_back(16'hBBBB);
        request(1, 2'b10, "st_ur_hold");
        check_value("st_ur_cnt", 32'(underrun_cnt_s), 1);
        check_value("st_ur_level", 32'(level_s), 1);
        exp_q.push_back(16'hBBBB);
        request(1, 2'b01, "st_right_idle");
        check_value("st_right_idle_level", 32'(level_s), 1);
        flush_s = 1'b1;
        tick();
        flush_s = 1'b0;
        check_value("st_flush_level", 32'(level_s), 0);

        // Stereo lost frame: R0 discarded.
        push_sample(1, 16'h0100);
        push_sample(1, 16'h0200);
        push_sample(1, 16'h0101);
        push_sample(1, 16'h0201);
        exp_q.push_back(16'h0100);
        request(1, 2'b10, "lost_L0");
        exp_q.push_back(16'h0101);
        request(1, 2'b10, "lost_L1");
        check_value("lost_level", 32'(level_s), 1);
        exp_q.push_back(16'h0201);
        request(1, 2'b01, "lost_R1");
        check_value("lost_level_end", 32'(level_s), 0);

        // Stereo: both request bits, left wins.
        push_sample(1, 16'h7777);
        push_sample(1, 16'h8888);
        exp_q.push_back(16'h7777);
        request(1, 2'b11, "both_left");
        exp_q.push_back(16'h8888);
        request(1, 2'b01, "both_right");

        // Stereo mute.
        push_sample(1, 16'h1357);
        push_sample(1, 16'h2468);
        enable_s = 1'b0;
        exp_q.push_back(16'h0000);
        request(1, 2'b10, "st_mute");
        enable_s = 1'b1;
        check_value("st_mute_level", 32'(level_s), 2);
        exp_q.push_back(16'h1357);
        request(1, 2'b10, "st_unmute_L");
        exp_q.push_back(16'h2468);
        request(1, 2'b01, "st_unmute_R");
        check_value("st_cnt_final", 32'(underrun_cnt_s), 1);

        // Asynchronous reset between clock edges.
        push_sample(0, 16'h5555);
        push_sample(1, 16'h6666);
        #1;
        reset_m = 1'b0;
        reset_s = 1'b0;
        #1;
        check_value("async_level_m", 32'(level_m), 0);
        check_value("async_audio_m", 32'(audio_output_m), 0);
        check_value("async_cnt_m", 32'(underrun_cnt_m), 0);
        check_value("async_audio_s", 32'(audio_output_s), 0);
        check_value("async_level_s", 32'(level_s), 0);
        check_value("async_cnt_s", 32'(underrun_cnt_s), 0);
        tick();
        reset_m = 1'b1;
        reset_s = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
